// File: rtl/demux_4_buf.sv
// demux_4_buf: routes one valid/ready stream to four buffered channels; DEMUX_CNT_EN adds per-channel pop counters
module demux_4_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
`ifdef DEMUX_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_select,
    output logic             in_ready,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3
`ifdef DEMUX_CNT_EN
    ,
    input  logic [1:0]       cnt_sel,
    output logic [CNT_W-1:0] cnt_out
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [3:0] full, push, pop;
    logic [WIDTH-1:0] head [4];
`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0] xfer [4];
    assign cnt_out = xfer[cnt_sel];
`endif
    // full is registered state, so a same-cycle pop never frees a slot for the push
    assign in_ready = !full[in_select];
    assign out_data0 = head[0];
    assign out_data1 = head[1];
    assign out_data2 = head[2];
    assign out_data3 = head[3];
    for (genvar k = 0; k < 4; k++) begin : g_ch
        logic [WIDTH-1:0] mem [DEPTH];
        logic [PW-1:0] rd, wr;
        logic [CW-1:0] cnt;
        assign push[k] = in_valid && in_ready && in_select == 2'(k);
        assign pop[k] = out_valid[k] && out_ready[k];
        assign full[k] = cnt == CW'(DEPTH);
        assign out_valid[k] = cnt != '0;
        assign head[k] = out_valid[k] ? mem[rd] : '0;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mem <= '{default: '0};
                rd <= '0;
                wr <= '0;
                cnt <= '0;
            end else begin
                if (push[k]) mem[wr] <= in_data;
                if (push[k]) wr <= wr + 1'b1;
                if (pop[k]) rd <= rd + 1'b1;
                cnt <= cnt + CW'(push[k]) - CW'(pop[k]);
            end
        end
`ifdef DEMUX_CNT_EN
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) xfer[k] <= '0;
            else if (pop[k]) xfer[k] <= xfer[k] + 1'b1;
        end
`endif
    end
endmodule

// File: tb/tb_demux_4_buf.sv
// tb_demux_4_buf: table-driven directed checks of demux_4_buf with an occupancy model
module tb_demux_4_buf;
    localparam int DEPTH = 2;
    logic clk = 0, rst_n, in_valid, in_ready;
    logic [31:0] in_data, out_data0, out_data1, out_data2, out_data3;
    logic [1:0] in_select;
    logic [3:0] out_valid, out_ready;
    logic [31:0] od [4];
`ifdef DEMUX_CNT_EN
    logic [1:0] cnt_sel;
    logic [15:0] cnt_out;
`endif
    int tests = 0, fails = 0;
    int occ [4] = '{0, 0, 0, 0};
    typedef struct {
        bit v; bit [1:0] s; logic [31:0] d; bit [3:0] r;
        bit rdy; bit [3:0] ov; bit [1:0] ch; logic [31:0] ed;
    } vec_t;
    vec_t tbl[$];

    assign od[0] = out_data0;
    assign od[1] = out_data1;
    assign od[2] = out_data2;
    assign od[3] = out_data3;

    always #5 clk = ~clk;

    demux_4_buf #(.WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_select(in_select), .in_ready(in_ready), .out_valid(out_valid),
        .out_ready(out_ready), .out_data0(out_data0), .out_data1(out_data1),
        .out_data2(out_data2), .out_data3(out_data3)
`ifdef DEMUX_CNT_EN
        , .cnt_sel(cnt_sel), .cnt_out(cnt_out)
`endif
    );

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    task automatic check_idle(input string n);
        chk({n, "_valid"}, 32'(out_valid), 32'h0);
        chk({n, "_ready"}, 32'(in_ready), 32'h1);
        for (int k = 0; k < 4; k++) chk($sformatf("%s_data%0d", n, k), od[k], 32'h0);
    endtask

    // Starts just after a falling edge and returns on the next falling edge.
    task automatic step(input vec_t t);
        bit psh;
        bit [3:0] pp;
        in_valid = t.v; in_select = t.s; in_data = t.d; out_ready = t.r;
        #1;
        chk($sformatf("in_ready sel%0d", t.s), 32'(in_ready), 32'(t.rdy));
        psh = t.v && occ[t.s] < DEPTH;
        for (int k = 0; k < 4; k++) pp[k] = occ[k] > 0 && t.r[k];
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            occ[k] += ((psh && t.s == 2'(k)) ? 1 : 0) - (pp[k] ? 1 : 0);
            tests++;
            if (occ[k] < 0 || occ[k] > DEPTH) begin
                fails++;
                $display("FAIL occ_bound ch%0d: got %0d required 0..%0d", k, occ[k], DEPTH);
            end
            chk($sformatf("occ_valid ch%0d", k), 32'(out_valid[k]), 32'(occ[k] != 0));
            if (k == t.ch) chk($sformatf("out_data%0d", k), od[k], t.ed);
            else if (!t.ov[k]) chk($sformatf("out_data%0d_zero", k), od[k], 32'h0);
        end
        chk("out_valid", 32'(out_valid), 32'(t.ov));
        @(negedge clk);
    endtask

    initial begin
        // v, sel, data, out_ready, exp in_ready, exp out_valid, checked ch, exp data
        tbl.push_back('{1, 2, 32'hDEADBEEF, 4'b0000, 1, 4'b0100, 2, 32'hDEADBEEF});
        tbl.push_back('{0, 0, 32'h0, 4'b0000, 1, 4'b0100, 0, 32'h0});
        tbl.push_back('{0, 2, 32'h0, 4'b0100, 1, 4'b0000, 2, 32'h0});
        tbl.push_back('{1, 1, 32'h11, 4'b0000, 1, 4'b0010, 1, 32'h11});
        tbl.push_back('{1, 1, 32'h22, 4'b0000, 1, 4'b0010, 1, 32'h11});
        tbl.push_back('{1, 1, 32'h33, 4'b0000, 0, 4'b0010, 1, 32'h11});
        tbl.push_back('{0, 1, 32'h0, 4'b0000, 0, 4'b0010, 1, 32'h11});
        tbl.push_back('{0, 0, 32'h0, 4'b0000, 1, 4'b0010, 1, 32'h11});
        tbl.push_back('{1, 1, 32'h33, 4'b0010, 0, 4'b0010, 1, 32'h22});
        tbl.push_back('{0, 1, 32'h0, 4'b0000, 1, 4'b0010, 1, 32'h22});
        tbl.push_back('{0, 1, 32'h0, 4'b0010, 1, 4'b0000, 1, 32'h0});
        tbl.push_back('{1, 3, 32'hA, 4'b0000, 1, 4'b1000, 3, 32'hA});
        tbl.push_back('{1, 3, 32'hB, 4'b1000, 1, 4'b1000, 3, 32'hB});
        tbl.push_back('{0, 3, 32'h0, 4'b1000, 1, 4'b0000, 3, 32'h0});
        tbl.push_back('{1, 0, 32'hC0, 4'b0001, 1, 4'b0001, 0, 32'hC0});
        tbl.push_back('{0, 0, 32'h0, 4'b0001, 1, 4'b0000, 0, 32'h0});
        for (int i = 0; i < 8; i++)
            tbl.push_back('{1, 2'(i % 4), 32'(i), 4'b1111, 1, 4'(1 << (i % 4)), 2'(i % 4), 32'(i)});
        tbl.push_back('{0, 0, 32'h0, 4'b1111, 1, 4'b0000, 0, 32'h0});

        rst_n = 0; in_valid = 1; in_select = 0; in_data = 32'h55; out_ready = 0;
`ifdef DEMUX_CNT_EN
        cnt_sel = 0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        @(negedge clk);
        in_valid = 0;
        rst_n = 1;
        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        step('{1, 0, 32'h100, 4'b0000, 1, 4'b0001, 0, 32'h100});
        step('{1, 1, 32'h101, 4'b0000, 1, 4'b0011, 1, 32'h101});
        step('{1, 2, 32'h102, 4'b0000, 1, 4'b0111, 2, 32'h102});
        in_valid = 0;
        #2 rst_n = 0;
        #1;
        check_idle("async_reset");
        occ = '{0, 0, 0, 0};
`ifdef DEMUX_CNT_EN
        for (int s = 0; s < 4; s++) begin
            cnt_sel = 2'(s);
            #1 chk($sformatf("cnt_reset sel%0d", s), 32'(cnt_out), 32'h0);
        end
`endif
        @(negedge clk);
        rst_n = 1;
        step('{1, 0, 32'h200, 4'b0001, 1, 4'b0001, 0, 32'h200});
        step('{1, 0, 32'h201, 4'b0001, 1, 4'b0001, 0, 32'h201});
        step('{1, 0, 32'h202, 4'b0001, 1, 4'b0001, 0, 32'h202});
        step('{0, 0, 32'h0, 4'b0001, 1, 4'b0000, 0, 32'h0});
`ifdef DEMUX_CNT_EN
        cnt_sel = 0;
        #1 chk("cnt ch0", 32'(cnt_out), 32'd3);
        cnt_sel = 1;
        #1 chk("cnt ch1", 32'(cnt_out), 32'd0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
